// File: rtl/mesi_isc_pkg.sv
// Shared types and constants for the MESI ISC broadcast sequencer.
package mesi_isc_pkg;

  localparam int CPU_COUNT = 4;

  // Per-CPU coherence bus command encoding.
  typedef enum logic [2:0] {
    CBUS_CMD_NOP      = 3'd0,
    CBUS_CMD_WR_SNOOP = 3'd1,
    CBUS_CMD_RD_SNOOP = 3'd2,
    CBUS_CMD_EN_WR    = 3'd3,
    CBUS_CMD_EN_RD    = 3'd4
  } cbus_cmd_e;

  // Broadcast FIFO entry type; encoding 3 is treated like NOP.
  typedef enum logic [1:0] {
    BROAD_NOP = 2'd0,
    BROAD_WR  = 2'd1,
    BROAD_RD  = 2'd2
  } broad_type_e;

  // Sequencer FSM state.
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_SNOOP  = 2'd1,
    SEQ_ENABLE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/mesi_isc_snoop_mask.sv
// Tracks which snoopees have acked the active broadcast.
// driven_o marks CPUs still receiving a snoop command; all_snooped_o
// already includes the acks of the current cycle.
module mesi_isc_snoop_mask
  import mesi_isc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           orig_i,
  input  logic [CPU_COUNT-1:0] ack_i,
  input  logic                 snoop_en_i,
  input  logic                 clear_i,
  output logic [CPU_COUNT-1:0] done_mask_o,
  output logic [CPU_COUNT-1:0] driven_o,
  output logic                 all_snooped_o
);

  logic [CPU_COUNT-1:0] mask_q, mask_d;
  logic [CPU_COUNT-1:0] orig_oh;
  logic [CPU_COUNT-1:0] acked;

  // Only acks from CPUs currently driven with a snoop count.
  always_comb begin
    orig_oh       = CPU_COUNT'(1) << orig_i;
    driven_o      = snoop_en_i ? (~mask_q & ~orig_oh) : '0;
    acked         = ack_i & driven_o;
    mask_d        = clear_i ? '0 : (mask_q | acked);
    all_snooped_o = &(mask_q | acked | orig_oh);
  end

  // Mask register; cleared on reset and when a transaction retires or aborts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign done_mask_o = mask_q;

endmodule

// File: rtl/mesi_isc_broad_sequencer.sv
// Broadcast sequencer: pops the broadcast FIFO head, snoops the three
// non-originating CPUs, then enables the originator and retires.
// Optional ack watchdog: define MESI_ISC_BROAD_SEQ_TIMEOUT_EN.
// Handshake: broad_fifo_rd_o pops the head in the same cycle it is high
// (head fields are captured on that edge); each cbus_ack_array_i[i] is a
// single-cycle ack, counted only while CPU i is being driven.
module mesi_isc_broad_sequencer
  import mesi_isc_pkg::*;
#(
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 7,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                broad_fifo_status_empty_i,
  input  logic [ADDR_WIDTH-1:0]               broad_addr_i,
  input  logic [BROAD_TYPE_WIDTH-1:0]         broad_type_i,
  input  logic [1:0]                          broad_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]           broad_id_i,
  input  logic [CPU_COUNT-1:0]                cbus_ack_array_i,
  output logic                                broad_fifo_rd_o,
  output logic [ADDR_WIDTH-1:0]               cbus_addr_o,
  output logic [CPU_COUNT*CBUS_CMD_WIDTH-1:0] cbus_cmd_array_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [BROAD_ID_WIDTH-1:0]           done_id_o,
  output logic                                timeout_err_o,
  output logic [1:0]                          dbg_state_o
);

  seq_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [1:0]                cpu_q;
  logic [BROAD_ID_WIDTH-1:0] id_q, done_id_q;
  logic                      is_rd_q;
  logic                      done_q, done_d;
  logic                      capture, mask_clear;
  logic                      head_is_wr, head_is_rd;
  logic [CPU_COUNT-1:0]      done_mask, driven;
  logic                      all_snooped;
  logic                      timeout_hit;

  assign head_is_wr = (broad_type_i == BROAD_TYPE_WIDTH'(BROAD_WR));
  assign head_is_rd = (broad_type_i == BROAD_TYPE_WIDTH'(BROAD_RD));

  mesi_isc_snoop_mask u_snoop_mask (
    .clk           (clk),
    .rst           (rst),
    .orig_i        (cpu_q),
    .ack_i         (cbus_ack_array_i),
    .snoop_en_i    (state_q == SEQ_SNOOP),
    .clear_i       (mask_clear),
    .done_mask_o   (done_mask),
    .driven_o      (driven),
    .all_snooped_o (all_snooped)
  );

  // Next-state and command decode; the watchdog overrides normal progress.
  always_comb begin
    state_d          = state_q;
    broad_fifo_rd_o  = 1'b0;
    capture          = 1'b0;
    busy_o           = 1'b0;
    done_d           = 1'b0;
    mask_clear       = 1'b0;
    cbus_cmd_array_o = '0;
    case (state_q)
      SEQ_IDLE: begin
        if (!broad_fifo_status_empty_i) begin
          broad_fifo_rd_o = 1'b1;
          capture         = 1'b1;
          if (head_is_wr || head_is_rd) state_d = SEQ_SNOOP;
        end
      end
      SEQ_SNOOP: begin
        busy_o = 1'b1;
        for (int i = 0; i < CPU_COUNT; i++) begin
          if (driven[i]) begin
            cbus_cmd_array_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = is_rd_q ?
              CBUS_CMD_WIDTH'(CBUS_CMD_RD_SNOOP) : CBUS_CMD_WIDTH'(CBUS_CMD_WR_SNOOP);
          end
        end
        if (all_snooped) state_d = SEQ_ENABLE;
      end
      SEQ_ENABLE: begin
        busy_o = 1'b1;
        for (int i = 0; i < CPU_COUNT; i++) begin
          if (i == int'(cpu_q)) begin
            cbus_cmd_array_o[i*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] = is_rd_q ?
              CBUS_CMD_WIDTH'(CBUS_CMD_EN_RD) : CBUS_CMD_WIDTH'(CBUS_CMD_EN_WR);
          end
        end
        if (cbus_ack_array_i[cpu_q]) begin
          state_d    = SEQ_IDLE;
          done_d     = 1'b1;
          mask_clear = 1'b1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    if (timeout_hit) begin
      state_d    = SEQ_IDLE;
      done_d     = 1'b0;
      mask_clear = 1'b1;
    end
  end

  // State, captured head fields and the registered retire pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SEQ_IDLE;
      addr_q    <= '0;
      cpu_q     <= '0;
      id_q      <= '0;
      is_rd_q   <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (capture) begin
        addr_q  <= broad_addr_i;
        cpu_q   <= broad_cpu_id_i;
        id_q    <= broad_id_i;
        is_rd_q <= head_is_rd;
      end
      if (done_d) done_id_q <= id_q;
    end
  end

`ifdef MESI_ISC_BROAD_SEQ_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  assign timeout_hit = (state_q != SEQ_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every state change and runs only while busy.
  always_comb begin
    cnt_d = '0;
    if (state_d != SEQ_IDLE && state_d == state_q) cnt_d = cnt_q + 1'b1;
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign timeout_err_o = err_q;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
  assign timeout_err_o         = 1'b0;
`endif

  logic [CPU_COUNT-1:0] unused_done_mask;
  assign unused_done_mask = done_mask;

  assign cbus_addr_o = addr_q;
  assign done_o      = done_q;
  assign done_id_o   = done_id_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mesi_isc_broad_sequencer.sv
// Directed bench for mesi_isc_broad_sequencer with a retire-ID scoreboard.
// Define MESI_ISC_BROAD_SEQ_TIMEOUT_EN to also exercise the watchdog.
module tb_mesi_isc_broad_sequencer;
  import mesi_isc_pkg::*;

  localparam int W  = 3;
  localparam int AW = 32;
  localparam int TW = 2;
  localparam int IW = 7;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          empty;
  logic [AW-1:0] addr;
  logic [TW-1:0] btype;
  logic [1:0]    cpu;
  logic [IW-1:0] id;
  logic [3:0]    ack;
  logic          rd_o;
  logic [AW-1:0] cbus_addr_o;
  logic [4*W-1:0] cmds;
  logic          busy_o, done_o, err_o;
  logic [IW-1:0] done_id_o;
  logic [1:0]    dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int pop_cnt  = 0;
  logic [IW-1:0] exp_q[$];
  int ack_at[3];

  mesi_isc_broad_sequencer #(
    .CBUS_CMD_WIDTH(W), .ADDR_WIDTH(AW), .BROAD_TYPE_WIDTH(TW),
    .BROAD_ID_WIDTH(IW), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .broad_fifo_status_empty_i (empty),
    .broad_addr_i              (addr),
    .broad_type_i              (btype),
    .broad_cpu_id_i            (cpu),
    .broad_id_i                (id),
    .cbus_ack_array_i          (ack),
    .broad_fifo_rd_o           (rd_o),
    .cbus_addr_o               (cbus_addr_o),
    .cbus_cmd_array_o          (cmds),
    .busy_o                    (busy_o),
    .done_o                    (done_o),
    .done_id_o                 (done_id_o),
    .timeout_err_o             (err_o),
    .dbg_state_o               (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cmds(input string tag, input logic [2:0] c0, input logic [2:0] c1,
                          input logic [2:0] c2, input logic [2:0] c3);
    chk(tag, 32'(cmds), 32'({c3, c2, c1, c0}));
  endtask

  function automatic logic [2:0] cmd_of(input int c);
    return cmds[c*W +: W];
  endfunction

  // driver: advance one cycle, acks default low, inputs change 2 units after the edge
  task automatic cyc();
    @(posedge clk);
    #2;
    ack = 4'b0000;
  endtask

  // scoreboard: every retire must match the oldest expected ID
  always @(negedge clk) begin
    if (rst && rd_o) pop_cnt++;
    if (rst && done_o) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'(done_o), 32'd0);
      else chk("done_id_sb", 32'(done_id_o), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    empty = 1'b1; addr = '0; btype = '0; cpu = '0; id = '0; ack = '0;
    #3;
    chk("rst_cmds", 32'(cmds), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_addr", cbus_addr_o, 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_done_id", 32'(done_id_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(SEQ_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // empty FIFO: nothing happens
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      chk("idle_rd", 32'(rd_o), 32'd0);
      chk("idle_cmds", 32'(cmds), 32'd0);
      chk("idle_busy", 32'(busy_o), 32'd0);
    end

    // WR from cpu1, all snoop acks in first SNOOP cycle; done in the 4th cycle counting the pop
    cyc(); empty = 1'b0; btype = 2'd1; cpu = 2'd1; addr = 32'h1000; id = 7'd5; #1;
    chk("t2_pop", 32'(rd_o), 32'd1);
    chk("t2_busy_pop", 32'(busy_o), 32'd0);
    exp_q.push_back(7'd5);
    cyc(); empty = 1'b1; ack = 4'b1101; #1;
    chk_cmds("t2_snoop", 3'd1, 3'd0, 3'd1, 3'd1);
    chk("t2_busy", 32'(busy_o), 32'd1);
    chk("t2_addr", cbus_addr_o, 32'h1000);
    chk("t2_state", 32'(dbg_state), 32'(SEQ_SNOOP));
    cyc(); ack = 4'b0010; #1;
    chk_cmds("t2_enable", 3'd0, 3'd3, 3'd0, 3'd0);
    cyc(); #1;
    chk("t2_done", 32'(done_o), 32'd1);
    chk("t2_done_id", 32'(done_id_o), 32'd5);
    chk_cmds("t2_idle", 3'd0, 3'd0, 3'd0, 3'd0);
    chk("t2_busy_end", 32'(busy_o), 32'd0);
    cyc(); #1;
    chk("t2_done_pulse", 32'(done_o), 32'd0);

    // RD from cpu3, staggered acks (cycles counted from the pop), plus ignored stray acks
    cyc(); empty = 1'b0; btype = 2'd2; cpu = 2'd3; addr = 32'h2000; id = 7'd9; #1;
    chk("t3_pop", 32'(rd_o), 32'd1);
    exp_q.push_back(7'd9);
    ack_at = '{2, 7, 5};
    for (int k = 1; k <= 9; k++) begin
      cyc(); empty = 1'b1;
      for (int c = 0; c < 3; c++) if (k == ack_at[c]) ack[c] = 1'b1;
      if (k == 3) ack[3] = 1'b1;  // originator ack during snoop
      if (k == 4) ack[0] = 1'b1;  // repeat ack from an already-done CPU
      if (k == 9) ack[3] = 1'b1;  // enable ack
      #1;
      for (int c = 0; c < 4; c++) begin
        logic [2:0] e;
        e = 3'd0;
        if (k <= 7) begin
          if (c != 3 && k <= ack_at[c]) e = 3'd2;
        end else if (c == 3) begin
          e = 3'd4;
        end
        chk($sformatf("t3_cmd_k%0d_cpu%0d", k, c), 32'(cmd_of(c)), 32'(e));
      end
    end
    cyc(); #1;
    chk("t3_done", 32'(done_o), 32'd1);
    chk("t3_done_id", 32'(done_id_o), 32'd9);

    // NOP and type-3 entries discarded, then RD from cpu0 popped the next cycle
    cyc(); empty = 1'b0; btype = 2'd0; cpu = 2'd2; id = 7'd11; addr = 32'h4444; #1;
    chk("t4_nop_pop", 32'(rd_o), 32'd1);
    chk_cmds("t4_nop_cmds", 3'd0, 3'd0, 3'd0, 3'd0);
    cyc(); btype = 2'd3; id = 7'd12; addr = 32'h5555; #1;
    chk("t4_t3_pop", 32'(rd_o), 32'd1);
    chk("t4_t3_busy", 32'(busy_o), 32'd0);
    chk("t4_nop_addr", cbus_addr_o, 32'h4444);
    cyc(); btype = 2'd2; cpu = 2'd0; id = 7'd13; addr = 32'h3000; #1;
    chk("t4_rd_pop", 32'(rd_o), 32'd1);
    chk_cmds("t4_t3_cmds", 3'd0, 3'd0, 3'd0, 3'd0);
    exp_q.push_back(7'd13);
    cyc(); empty = 1'b1; ack = 4'b1110; #1;
    chk_cmds("t4_snoop", 3'd0, 3'd2, 3'd2, 3'd2);
    cyc(); ack = 4'b0001; #1;
    chk_cmds("t4_enable", 3'd4, 3'd0, 3'd0, 3'd0);
    cyc(); #1;
    chk("t4_done", 32'(done_o), 32'd1);
    chk("t4_addr", cbus_addr_o, 32'h3000);

    // reset during SNOOP abandons the transaction
    cyc(); empty = 1'b0; btype = 2'd1; cpu = 2'd2; id = 7'd20; addr = 32'h6000; #1;
    chk("t5_pop", 32'(rd_o), 32'd1);
    cyc(); empty = 1'b1; #1;
    chk_cmds("t5_snoop", 3'd1, 3'd1, 3'd0, 3'd1);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_cmds", 32'(cmds), 32'd0);
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    chk("t5_rst_addr", cbus_addr_o, 32'd0);
    cyc();
    @(negedge clk);
    rst = 1'b1;
    cyc(); #1;
    chk("t5_no_done", 32'(done_o), 32'd0);
    chk("t5_idle_cmds", 32'(cmds), 32'd0);
    cyc(); empty = 1'b0; btype = 2'd1; cpu = 2'd0; id = 7'd21; addr = 32'h7000; #1;
    chk("t5_new_pop", 32'(rd_o), 32'd1);
    exp_q.push_back(7'd21);
    cyc(); empty = 1'b1; ack = 4'b1110; #1;
    chk_cmds("t5_snoop2", 3'd0, 3'd1, 3'd1, 3'd1);
    cyc(); ack = 4'b0001; #1;
    chk_cmds("t5_enable", 3'd3, 3'd0, 3'd0, 3'd0);
    cyc(); #1;
    chk("t5_done", 32'(done_o), 32'd1);
    chk("t5_done_id", 32'(done_id_o), 32'd21);
    chk("pop_count", pop_cnt, 32'd7);

`ifdef MESI_ISC_BROAD_SEQ_TIMEOUT_EN
    // watchdog: cpu2 never acks
    cyc(); empty = 1'b0; btype = 2'd1; cpu = 2'd1; id = 7'd30; addr = 32'h8000; #1;
    chk("to_pop", 32'(rd_o), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      cyc(); empty = 1'b1;
      if (k == 1) ack = 4'b1001;
      #1;
      chk($sformatf("to_cpu2_k%0d", k), 32'(cmd_of(2)), 32'd1);
      chk($sformatf("to_err_k%0d", k), 32'(err_o), 32'd0);
    end
    cyc(); #1;
    chk("to_cmds", 32'(cmds), 32'd0);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_busy", 32'(busy_o), 32'd0);
    chk("to_state", 32'(dbg_state), 32'(SEQ_IDLE));
    repeat (3) begin
      cyc(); #1;
      chk("to_err_sticky", 32'(err_o), 32'd1);
    end
`else
    chk("no_timeout_err", 32'(err_o), 32'd0);
`endif

    repeat (3) cyc();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
